// File: rtl/rom_image_blitter_if.sv
// Pixel-stream bundle between the image blitter, its image ROM and the VGA adapter.
// The blitter side is the master: it drives ROM address and the plot stream.
interface rom_image_blitter_if;
  logic        start;
  logic [2:0]  rom_q;
  logic [14:0] rom_address;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  modport master (
    input  start, rom_q,
    output rom_address, x, y, colour, plot, busy, done
  );

  modport slave (
    output start, rom_q,
    input  rom_address, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/rom_image_blitter.sv
// Streams a row-major 3-bit image out of a single-port ROM into the VGA plot
// interface at one pixel per clock, with optional colour-key transparency.
module rom_image_blitter #(
  parameter int         IMG_W      = 160,
  parameter int         IMG_H      = 120,
  parameter int         BASE_ADDR  = 0,
  parameter int         X0         = 0,
  parameter int         Y0         = 0,
  parameter int         KEY_EN     = 0,
  parameter logic [2:0] KEY_COLOUR = 3'b000
) (
  input  logic                 clock,
  input  logic                 resetn,
  rom_image_blitter_if.master  bus
);

  if ((BASE_ADDR + IMG_W * IMG_H > 32768) || (IMG_W < 2) || (IMG_W > 256) ||
      (IMG_H < 1) || (IMG_H > 128)) begin : g_cfg_error
    $error("rom_image_blitter: image geometry does not fit the ROM or screen");
  end

  localparam logic [14:0] BASE_L   = 15'(BASE_ADDR);
  localparam logic [7:0]  X0_L     = 8'(X0);
  localparam logic [6:0]  Y0_L     = 7'(Y0);
  localparam logic [7:0]  LAST_COL = 8'(IMG_W - 1);
  localparam logic [6:0]  LAST_ROW = 7'(IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_DRAW  = 3'd2,
    S_FLUSH = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [14:0] addr_r, addr_s;
  logic [7:0]  col_r, col_s, col_d_r, col_d_s;
  logic [6:0]  row_r, row_s, row_d_r, row_d_s;
  logic [7:0]  x_r, x_s;
  logic [6:0]  y_r, y_s;
  logic [2:0]  colour_r, colour_s;
  logic        plot_r, plot_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        wrap_s;

  function automatic logic pixel_visible(input logic [2:0] q);
    if ((KEY_EN != 0) && (q == KEY_COLOUR)) begin
      return 1'b0;
    end else begin
      return 1'b1;
    end
  endfunction

  assign wrap_s = (col_r == LAST_COL);

  // Next-state and next-output logic; col/row track the address in flight,
  // col_d/row_d track the pixel whose data is on rom_q this cycle.
  always_comb begin
    state_s  = state_r;
    addr_s   = addr_r;
    col_s    = col_r;
    row_s    = row_r;
    col_d_s  = col_d_r;
    row_d_s  = row_d_r;
    x_s      = x_r;
    y_s      = y_r;
    colour_s = colour_r;
    plot_s   = 1'b0;
    busy_s   = busy_r;
    done_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        // The done cycle is already IDLE, so a start there must still be ignored.
        if (bus.start && !done_r) begin
          state_s = S_PRIME;
          addr_s  = BASE_L;
          col_s   = 8'd0;
          row_s   = 7'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_PRIME: begin
        state_s = S_DRAW;
        busy_s  = 1'b1;
        addr_s  = addr_r + 15'd1;
        col_d_s = col_r;
        row_d_s = row_r;
        if (wrap_s) begin
          col_s = 8'd0;
          row_s = row_r + 7'd1;
        end else begin
          col_s = col_r + 8'd1;
        end
      end
      S_DRAW: begin
        plot_s   = pixel_visible(bus.rom_q);
        colour_s = bus.rom_q;
        x_s      = X0_L + col_d_r;
        y_s      = Y0_L + row_d_r;
        col_d_s  = col_r;
        row_d_s  = row_r;
        if (wrap_s && (row_r == LAST_ROW)) begin
          state_s = S_FLUSH;
        end else if (wrap_s) begin
          addr_s = addr_r + 15'd1;
          col_s  = 8'd0;
          row_s  = row_r + 7'd1;
        end else begin
          addr_s = addr_r + 15'd1;
          col_s  = col_r + 8'd1;
        end
      end
      S_FLUSH: begin
        state_s  = S_FIN;
        plot_s   = pixel_visible(bus.rom_q);
        colour_s = bus.rom_q;
        x_s      = X0_L + col_d_r;
        y_s      = Y0_L + row_d_r;
      end
      S_FIN: begin
        state_s = S_IDLE;
        done_s  = 1'b1;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = S_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r  <= S_IDLE;
      addr_r   <= 15'd0;
      col_r    <= 8'd0;
      row_r    <= 7'd0;
      col_d_r  <= 8'd0;
      row_d_r  <= 7'd0;
      x_r      <= 8'd0;
      y_r      <= 7'd0;
      colour_r <= 3'd0;
      plot_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      addr_r   <= addr_s;
      col_r    <= col_s;
      row_r    <= row_s;
      col_d_r  <= col_d_s;
      row_d_r  <= row_d_s;
      x_r      <= x_s;
      y_r      <= y_s;
      colour_r <= colour_s;
      plot_r   <= plot_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign bus.rom_address = addr_r;
  assign bus.x           = x_r;
  assign bus.y           = y_r;
  assign bus.colour      = colour_r;
  assign bus.plot        = plot_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_rom_image_blitter.sv
// Three blitter configurations (full screen, offset/base, colour key) checked
// each cycle against a timing model computed from draw start.
module tb_rom_image_blitter;

  localparam int         NI = 3;
  localparam int         PW  [NI] = '{160, 4, 4};
  localparam int         PH  [NI] = '{120, 2, 2};
  localparam int         PB  [NI] = '{0, 100, 0};
  localparam int         PX0 [NI] = '{0, 10, 0};
  localparam int         PY0 [NI] = '{0, 5, 0};
  localparam int         PKE [NI] = '{0, 0, 1};
  localparam logic [2:0] PKC [NI] = '{3'd0, 3'd0, 3'd0};

  logic        clock;
  logic        resetn;
  logic [2:0]  st;
  logic [2:0]  mem_off [8];

  logic [14:0] a_addr   [NI];
  logic [7:0]  a_x      [NI];
  logic [6:0]  a_y      [NI];
  logic [2:0]  a_colour [NI];
  logic        a_plot   [NI];
  logic        a_busy   [NI];
  logic        a_done   [NI];

  logic        m_act   [NI];
  logic        m_drawn [NI];
  int          m_t     [NI];

  int chk = 0;
  int err = 0;

  // monitor captures
  int p0_cnt = 0, b0_cnt = 0, d0_cnt = 0;
  int fp_t = -1, lp_t = -1, dn_t = -1;
  int c159_0 = -1, c0_1 = -1, c_last = -1;
  int a1 [8];
  int px1 [8], py1 [8], pc1 [8];
  int p2_cnt = 0, d2_cnt = 0, d2_t = -1, x2 = -1, y2 = -1, col2 = -1;

  function automatic logic [2:0] rom_val(input int i, input int a);
    if (i == 0) return 3'(a % 8);
    else if (i == 1) return mem_off[(a - 100) & 7];
    else return (a == 3) ? 3'd5 : 3'd0;
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    rom_image_blitter_if bus ();
    rom_image_blitter #(
      .IMG_W(PW[gi]), .IMG_H(PH[gi]), .BASE_ADDR(PB[gi]),
      .X0(PX0[gi]), .Y0(PY0[gi]), .KEY_EN(PKE[gi]), .KEY_COLOUR(PKC[gi])
    ) u_dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
    );
    assign bus.start    = st[gi];
    assign a_addr[gi]   = bus.rom_address;
    assign a_x[gi]      = bus.x;
    assign a_y[gi]      = bus.y;
    assign a_colour[gi] = bus.colour;
    assign a_plot[gi]   = bus.plot;
    assign a_busy[gi]   = bus.busy;
    assign a_done[gi]   = bus.done;
    // ROM: address registered on the edge, data readable until the next edge
    always @(posedge clock) bus.rom_q <= rom_val(gi, int'(bus.rom_address));
  end

  // Reference: cycles elapsed since the accepted start edge of each instance.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NI; i++) begin
        m_act[i]   <= 1'b0;
        m_drawn[i] <= 1'b0;
        m_t[i]     <= 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (m_act[i]) begin
          if (m_t[i] >= PW[i] * PH[i] + 2) m_act[i] <= 1'b0;
          else m_t[i] <= m_t[i] + 1;
        end else if (st[i]) begin
          m_act[i]   <= 1'b1;
          m_drawn[i] <= 1'b1;
          m_t[i]     <= 0;
        end
      end
    end
  end

  task automatic check(input string name, input int i, input longint act, input longint exp);
    chk = chk + 1;
    if (act != exp) begin
      err = err + 1;
      $display("FAIL %s inst%0d at %0t: got %0d expected %0d", name, i, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, plus capture for literal checks.
  initial begin
    forever begin
      @(negedge clock);
      for (int i = 0; i < NI; i++) begin
        int n, t, k;
        logic e_plot, e_busy, e_done;
        int e_addr;
        n = PW[i] * PH[i];
        t = m_t[i];
        e_busy = m_act[i] && (t >= 1) && (t <= n + 1);
        e_done = m_act[i] && (t == n + 2);
        e_plot = 1'b0;
        k = t - 2;
        if (m_act[i] && (t >= 2) && (t <= n + 1))
          e_plot = !((PKE[i] != 0) && (rom_val(i, PB[i] + k) == PKC[i]));
        if (!m_drawn[i]) e_addr = 0;
        else if (m_act[i] && (t < n - 1)) e_addr = (PB[i] + t) % 32768;
        else e_addr = (PB[i] + n - 1) % 32768;
        check("plot", i, a_plot[i], e_plot);
        check("busy", i, a_busy[i], e_busy);
        check("done", i, a_done[i], e_done);
        check("rom_address", i, a_addr[i], e_addr);
        if (e_plot) begin
          check("x", i, a_x[i], (PX0[i] + k % PW[i]) % 256);
          check("y", i, a_y[i], (PY0[i] + k / PW[i]) % 128);
          check("colour", i, a_colour[i], rom_val(i, PB[i] + k));
        end else if (!m_drawn[i]) begin
          check("x_idle", i, a_x[i], 0);
          check("y_idle", i, a_y[i], 0);
          check("colour_idle", i, a_colour[i], 0);
        end
        if (i == 0) begin
          if (a_plot[0]) begin
            p0_cnt = p0_cnt + 1;
            if (a_x[0] == 8'd0 && a_y[0] == 7'd0) fp_t = t;
            if (a_x[0] == 8'd159 && a_y[0] == 7'd0) c159_0 = a_colour[0];
            if (a_x[0] == 8'd0 && a_y[0] == 7'd1) c0_1 = a_colour[0];
            if (a_x[0] == 8'd159 && a_y[0] == 7'd119) begin
              c_last = a_colour[0];
              lp_t   = t;
            end
          end
          if (a_busy[0]) b0_cnt = b0_cnt + 1;
          if (a_done[0]) begin
            d0_cnt = d0_cnt + 1;
            dn_t   = t;
          end
        end else if (i == 1) begin
          if (m_act[1] && t <= 7) a1[t] = a_addr[1];
          if (a_plot[1] && t >= 2 && t <= 9) begin
            px1[t-2] = a_x[1];
            py1[t-2] = a_y[1];
            pc1[t-2] = a_colour[1];
          end
        end else begin
          if (a_plot[2]) begin
            p2_cnt = p2_cnt + 1;
            x2 = a_x[2];
            y2 = a_y[2];
            col2 = a_colour[2];
          end
          if (a_done[2]) begin
            d2_cnt = d2_cnt + 1;
            d2_t = t;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic pulse(input int i);
    st[i] = 1'b1;
    step();
    st[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      step();
      n = n + 1;
      if (a_done[i]) seen = 1'b1;
    end
    check("done_seen", i, seen, 1);
  endtask

  task automatic full_draw_literals(input int ps, input int bs, input int ds);
    check("lit_plot_count", 0, p0_cnt - ps, 19200);
    check("lit_busy_cycles", 0, b0_cnt - bs, 19201);
    check("lit_done_count", 0, d0_cnt - ds, 1);
    check("lit_first_plot_t", 0, fp_t, 2);
    check("lit_last_plot_t", 0, lp_t, 19201);
    check("lit_done_t", 0, dn_t, 19202);
    check("lit_colour_159_0", 0, c159_0, 7);
    check("lit_colour_0_1", 0, c0_1, 0);
    check("lit_colour_last", 0, c_last, 7);
  endtask

  initial begin
    int ps, bs, ds, n;
    resetn = 1'b0;
    st = 3'b000;
    for (int j = 0; j < 8; j++) mem_off[j] = 3'($urandom_range(0, 7));

    // reset then idle
    repeat (3) step();
    resetn = 1'b1;
    repeat (50) step();
    check("lit_idle_addr", 0, a_addr[0], 0);
    check("lit_idle_plot", 0, a_plot[0], 0);
    check("lit_idle_busy", 0, a_busy[0], 0);

    // full draw, start re-pulsed mid-draw and on the done cycle
    ps = p0_cnt; bs = b0_cnt; ds = d0_cnt;
    pulse(0);
    repeat (50) step();
    pulse(0);
    wait_done(0, 20000);
    st[0] = 1'b1;
    step();
    step();
    st[0] = 1'b0;
    full_draw_literals(ps, bs, ds);
    step();
    check("lit_restart_busy", 0, a_busy[0], 1);

    // reset in the middle of the restarted draw
    n = 0;
    while (m_t[0] < 1002 && n < 3000) begin
      step();
      n = n + 1;
    end
    check("reach_pixel_1000", 0, m_t[0], 1002);
    ds = d0_cnt;
    resetn = 1'b0;
    #1;
    check("lit_rst_plot", 0, a_plot[0], 0);
    check("lit_rst_busy", 0, a_busy[0], 0);
    check("lit_rst_addr", 0, a_addr[0], 0);
    check("lit_rst_x", 0, a_x[0], 0);
    check("lit_rst_colour", 0, a_colour[0], 0);
    repeat (3) step();
    resetn = 1'b1;
    repeat (5) step();
    check("lit_no_done_after_abort", 0, d0_cnt - ds, 0);
    ps = p0_cnt; bs = b0_cnt; ds = d0_cnt;
    pulse(0);
    wait_done(0, 20000);
    step();
    full_draw_literals(ps, bs, ds);

    // offset/base and colour-key instances together
    ds = d2_cnt;
    n = p2_cnt;
    st[1] = 1'b1;
    st[2] = 1'b1;
    step();
    st = 3'b000;
    wait_done(1, 30);
    step();
    for (int j = 0; j < 8; j++) begin
      check("lit_off_addr", 1, a1[j], 100 + j);
      check("lit_off_x", 1, px1[j], 10 + j % 4);
      check("lit_off_y", 1, py1[j], 5 + j / 4);
      check("lit_off_colour", 1, pc1[j], mem_off[j]);
    end
    check("lit_key_plots", 2, p2_cnt - n, 1);
    check("lit_key_x", 2, x2, 3);
    check("lit_key_y", 2, y2, 0);
    check("lit_key_colour", 2, col2, 5);
    check("lit_key_done_t", 2, d2_t, 10);
    check("lit_key_done_count", 2, d2_cnt - ds, 1);

    // random start traffic with occasional resets on the small instances
    for (int c = 0; c < 600; c++) begin
      st[1] = ($urandom_range(0, 3) == 0);
      st[2] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 249) == 0) begin
        resetn = 1'b0;
        step();
        resetn = 1'b1;
      end
      step();
    end
    st = 3'b000;
    repeat (30) step();

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
